fa_nbit_serial: RTL

FA_NBIT_SERIAL -- requirements
Module: fa_nbit_serial

---
 rtl/fa_pkg.sv | 20 ++
 rtl/fa_1bit.sv | 13 +
 rtl/fa_nbit.sv | 31 +++
 rtl/fa_nbit_serial.sv | 105 ++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encodings and the
// helpers that derive the slice count and chunk-counter width.
package fa_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Number of CHUNK-wide slices in a W-bit word; degenerate CHUNK is caught at the top.
    function automatic int num_chunks(input int w, input int chunk);
        if (chunk < 1) return 1;
        return w / chunk;
    endfunction

    function automatic int cnt_width(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fa_1bit.sv
// Single-bit full adder cell used to build the ripple chain.
module fa_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/fa_nbit.sv
// Combinational WIDTH-bit ripple-carry adder; c_msb is the carry into the
// top bit so the caller can form signed overflow.
module fa_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_1bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[WIDTH];
    assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/fa_nbit_serial.sv
// Chunk-serial W-bit add/subtract: one CHUNK-wide slice per cycle through a
// shared fa_nbit, result held in DONE until the consumer takes it.
module fa_nbit_serial
    import fa_pkg::*;
#(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic [1:0]   state_dbg
);

    localparam int N  = num_chunks(W, CHUNK);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("fa_nbit_serial: CHUNK must be >= 1");
    end else if (W % CHUNK != 0) begin : g_bad_width
        $error("fa_nbit_serial: W must be a multiple of CHUNK");
    end

    logic [1:0]       state;
    logic [CW-1:0]    k;
    logic             carry;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_out;
    logic             c_msb;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; in_ready is high only in IDLE, out_valid only in DONE, and the
    // result stays frozen in DONE until out_ready is seen.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    assign a_sl = a_r[int'(k) * CHUNK +: CHUNK];
    assign b_sl = b_r[int'(k) * CHUNK +: CHUNK];

    fa_nbit #(.WIDTH(CHUNK)) u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .cin   (carry),
        .sum   (s_sl),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + ~borrow, so cout=1 means no borrow.
                        a_r   <= a;
                        b_r   <= b ^ {W{sub}};
                        carry <= cin ^ sub;
                        k     <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    sum[int'(k) * CHUNK +: CHUNK] <= s_sl;
                    carry <= c_out;
                    k     <= k + 1'b1;
                    if (k == LAST) begin
                        cout  <= c_out;
                        ovf   <= c_msb ^ c_out;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
